// File: rtl/inst_ram_axi_slave.sv
// AXI4 read-only slave serving single-outstanding bursts from a
// synchronous 32-bit instruction RAM (one-cycle read latency).
//
// Ports:
//   clk, resetn              clock, async active-low reset
//   AR*                      read address channel (ARLOCK/ARCACHE/
//                            ARPROT accepted but ignored)
//   R*                       read data channel
//   ram_en, ram_addr         RAM read strobe and word address
//   ram_rdata                RAM data, valid the cycle after ram_en
//
// Optional feature macro: INST_RAM_AXI_PREFETCH_EN
//   When defined, the next beat's RAM read is issued in the same
//   cycle as the current R handshake, giving one beat per cycle.
//   When undefined, every beat goes through a FETCH cycle.
module inst_ram_axi_slave #(
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        ARID,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic [1:0]        ARLOCK,
    input  logic [3:0]        ARCACHE,
    input  logic [2:0]        ARPROT,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [3:0]        RID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        arready_q;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  beat_q;
    logic        fresh_q;
    logic [31:0] hold_q;

    logic        ar_hs;
    logic        size_err;
    logic        dec_err;
    logic        next_err;
    logic        rlast;
    logic        advance;
    logic [31:0] next_addr;
    logic [31:0] ram_word;
    logic        unused_ok;

    assign ar_hs = ARVALID & arready_q & (state_q == IDLE);

    // Illegal size or WRAP/reserved burst poisons every beat.
    assign size_err = (size_q > 3'd2) | burst_q[1];

    // Any byte-address bit above the RAM's word range is a decode error.
    assign dec_err = (addr_q >> (RAM_AW + 2)) != 32'd0;

    assign next_addr = (burst_q == 2'b01)
                     ? addr_q + (32'd1 << size_q)
                     : addr_q;

    assign next_err = size_err
                    | ((next_addr >> (RAM_AW + 2)) != 32'd0);

    assign rlast = (beat_q == len_q);

    always_comb begin
        state_d  = state_q;
        ram_en   = 1'b0;
        ram_word = addr_q;
        advance  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ram_en  = ~(size_err | dec_err);
                state_d = RESP;
            end
            RESP: begin
                if (RREADY) begin
                    if (rlast) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
`ifdef INST_RAM_AXI_PREFETCH_EN
                        if (!next_err) begin
                            ram_en   = 1'b1;
                            ram_word = next_addr;
                        end else begin
                            state_d = FETCH;
                        end
`else
                        state_d = FETCH;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            fresh_q   <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == IDLE);
            fresh_q   <= ram_en;
            if (fresh_q) begin
                hold_q <= ram_rdata;
            end
            if (ar_hs) begin
                id_q    <= ARID;
                addr_q  <= ARADDR;
                len_q   <= ARLEN;
                size_q  <= ARSIZE;
                burst_q <= ARBURST;
                beat_q  <= '0;
            end else if (advance) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_addr;
            end
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = (state_q == RESP);
    assign RID     = RVALID ? id_q : 4'd0;
    assign RLAST   = RVALID & rlast;
    assign RRESP   = !RVALID ? 2'b00
                   : size_err ? 2'b10
                   : dec_err  ? 2'b11
                   : 2'b00;

    // Fresh RAM data is forwarded on its first cycle, then replayed
    // from the hold register while the master stalls.
    assign RDATA = (!RVALID | size_err | dec_err) ? 32'd0
                 : fresh_q ? ram_rdata
                 : hold_q;

    assign ram_addr = ram_en ? ram_word[RAM_AW+1:2] : '0;

    assign unused_ok = ^{ARLOCK, ARCACHE, ARPROT, ram_word, next_err};

endmodule

// File: tb/tb_inst_ram_axi_slave.sv
// Randomised and directed bench for inst_ram_axi_slave with an
// in-bench burst model and a per-cycle compare process.
module tb_inst_ram_axi_slave;

    localparam int AW = 16;
`ifdef INST_RAM_AXI_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        logic [15:0] word;
        int          cyc;
    } beat_t;

    logic          clk;
    logic          resetn;
    logic [3:0]    ARID;
    logic [31:0]   ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic [1:0]    ARLOCK;
    logic [3:0]    ARCACHE;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [3:0]    RID;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    logic rr_auto;
    logic rr_rand;
    logic rr_manual;
    assign RREADY = rr_auto ? rr_rand : rr_manual;

    int nchecks = 0;
    int nerr = 0;
    int cyc = 0;
    int since_rst = 0;

    beat_t expq[$];
    beat_t seen[$];
    bit    busy = 1'b0;
    bit    shown = 1'b1;
    int    due = 0;
    int    last_ar_cyc = 0;
    int    stall_cnt = 0;
    int    ram_en_cnt = 0;

    inst_ram_axi_slave #(.RAM_AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARLOCK    (ARLOCK),
        .ARCACHE   (ARCACHE),
        .ARPROT    (ARPROT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        since_rst <= resetn ? since_rst + 1 : 0;
    end

    initial begin
        rr_rand = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rr_rand = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic void chk(input string nm,
                                input logic [63:0] got,
                                input logic [63:0] want);
        nchecks++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, got, want, cyc);
        end
    endfunction

    // Expected beats of a burst, straight from the address rules.
    function automatic void push_burst(input logic [3:0]  id,
                                       input logic [31:0] addr,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size,
                                       input logic [1:0]  burst);
        beat_t       b;
        logic [31:0] a;
        for (int k = 0; k <= int'(len); k++) begin
            if (burst == 2'b00) a = addr;
            else a = addr + 32'(k) * (32'd1 << size);
            b.id   = id;
            b.last = (k == int'(len));
            b.word = a[AW+1:2];
            b.cyc  = 0;
            if (size > 3'd2 || burst[1]) begin
                b.resp = 2'b10;
                b.data = 32'd0;
            end else if ((a >> (AW + 2)) != 32'd0) begin
                b.resp = 2'b11;
                b.data = 32'd0;
            end else begin
                b.resp = 2'b00;
                b.data = mem[a[AW+1:2]];
            end
            expq.push_back(b);
        end
    endfunction

    always @(negedge clk) begin
        beat_t o;
        int    idx;
        if (!resetn) begin
            chk("reset_outputs",
                64'({ARREADY, RVALID, RLAST, RID, RDATA,
                     RRESP, ram_en, ram_addr}), 64'd0);
            expq.delete();
            busy  = 1'b0;
            shown = 1'b1;
        end else begin
            if (since_rst >= 1) chk("arready", 64'(ARREADY), 64'(!busy));
            if (ram_en) begin
                ram_en_cnt++;
                idx = (RVALID && RREADY) ? 1 : 0;
                nchecks++;
                if (!busy || expq.size() <= idx
                    || expq[idx].resp != 2'b00) begin
                    nerr++;
                    $display("FAIL ram_en: got 1 want 0 (cyc %0d)", cyc);
                end else begin
                    chk("ram_addr", 64'(ram_addr), 64'(expq[idx].word));
                end
            end
            if (busy && expq.size() > 0 && !shown) begin
                if (RVALID) begin
                    chk("rvalid_timing", 64'(cyc), 64'(due));
                    shown = 1'b1;
                end else if (cyc >= due) begin
                    chk("rvalid_late", 64'(RVALID), 64'd1);
                    shown = 1'b1;
                end
            end
            if (RVALID) begin
                if (expq.size() == 0) begin
                    chk("rvalid_unexpected", 64'(RVALID), 64'd0);
                end else begin
                    chk("rdata", 64'(RDATA), 64'(expq[0].data));
                    chk("rresp", 64'(RRESP), 64'(expq[0].resp));
                    chk("rlast", 64'(RLAST), 64'(expq[0].last));
                    chk("rid", 64'(RID), 64'(expq[0].id));
                    if (!RREADY) stall_cnt++;
                    if (RREADY) begin
                        o.data = RDATA;
                        o.resp = RRESP;
                        o.last = RLAST;
                        o.id   = RID;
                        o.word = '0;
                        o.cyc  = cyc;
                        seen.push_back(o);
                        if (expq[0].last) busy = 1'b0;
                        void'(expq.pop_front());
                        if (expq.size() > 0) begin
                            due = cyc + ((PF && expq[0].resp == 2'b00)
                                         ? 1 : 2);
                            shown = 1'b0;
                        end
                    end
                end
            end
            if (ARVALID && ARREADY && !busy) begin
                push_burst(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
                busy = 1'b1;
                due = cyc + 2;
                shown = 1'b0;
                last_ar_cyc = cyc;
            end
        end
    end

    task automatic ar_send(input logic [3:0]  id,
                           input logic [31:0] a,
                           input logic [7:0]  len,
                           input logic [2:0]  sz,
                           input logic [1:0]  bu);
        bit done;
        int t;
        ARID = id;
        ARADDR = a;
        ARLEN = len;
        ARSIZE = sz;
        ARBURST = bu;
        ARLOCK = 2'($urandom);
        ARCACHE = 4'($urandom);
        ARPROT = 3'($urandom);
        ARVALID = 1'b1;
        done = 1'b0;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            done = ARREADY && resetn;
            @(posedge clk);
            #1;
            t++;
        end
        ARVALID = 1'b0;
        if (!done) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_seen(input int n);
        int t;
        t = 0;
        while (seen.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (seen.size() < n) chk("seen_timeout", 64'(seen.size()), 64'(n));
    endtask

    initial begin
        int sel;
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;

        resetn = 1'b0;
        ARVALID = 1'b0;
        ARID = '0;
        ARADDR = '0;
        ARLEN = '0;
        ARSIZE = '0;
        ARBURST = '0;
        ARLOCK = '0;
        ARCACHE = '0;
        ARPROT = '0;
        rr_auto = 1'b0;
        rr_manual = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[16'h10] = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) mem[16'h40 + k] = 32'h11110000 + k;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("arready_rise", 64'(ARREADY), 64'd1);

        // Single beat.
        rr_manual = 1'b1;
        seen.delete();
        ar_send(4'd3, 32'h40, 8'd0, 3'd2, 2'b01);
        wait_idle();
        chk("single_count", 64'(seen.size()), 64'd1);
        if (seen.size() >= 1) begin
            chk("single_data", 64'(seen[0].data), 64'hDEADBEEF);
            chk("single_id", 64'(seen[0].id), 64'd3);
            chk("single_last", 64'(seen[0].last), 64'd1);
            chk("single_resp", 64'(seen[0].resp), 64'd0);
            chk("single_lat", 64'(seen[0].cyc - last_ar_cyc), 64'd2);
        end

        // INCR burst, continuous RREADY.
        seen.delete();
        ar_send(4'd1, 32'h100, 8'd3, 3'd2, 2'b01);
        wait_idle();
        chk("incr_count", 64'(seen.size()), 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            chk("incr_data", 64'(seen[k].data), 64'(32'h11110000 + k));
            chk("incr_last", 64'(seen[k].last), 64'(k == 3));
            if (k > 0)
                chk("incr_spacing", 64'(seen[k].cyc - seen[k-1].cyc),
                    PF ? 64'd1 : 64'd2);
        end

        // Backpressure on beat 1.
        seen.delete();
        stall_cnt = 0;
        ar_send(4'd2, 32'h100, 8'd3, 3'd2, 2'b01);
        wait_seen(1);
        rr_manual = 1'b0;
        repeat (5) @(posedge clk);
        #1 rr_manual = 1'b1;
        wait_idle();
        chk("bp_count", 64'(seen.size()), 64'd4);
        chk("bp_stall", 64'(stall_cnt), PF ? 64'd5 : 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk("bp_data", 64'(seen[k].data), 64'(32'h11110000 + k));

        // Bad size.
        seen.delete();
        ram_en_cnt = 0;
        ar_send(4'd4, 32'h40, 8'd1, 3'd4, 2'b01);
        wait_idle();
        chk("slverr_count", 64'(seen.size()), 64'd2);
        for (int k = 0; k < 2 && k < seen.size(); k++) begin
            chk("slverr_resp", 64'(seen[k].resp), 64'd2);
            chk("slverr_data", 64'(seen[k].data), 64'd0);
        end
        chk("slverr_ram_en", 64'(ram_en_cnt), 64'd0);

        // Out of range.
        seen.delete();
        ram_en_cnt = 0;
        ar_send(4'd5, 32'h0004_0000, 8'd0, 3'd2, 2'b01);
        wait_idle();
        chk("decerr_count", 64'(seen.size()), 64'd1);
        if (seen.size() >= 1) begin
            chk("decerr_resp", 64'(seen[0].resp), 64'd3);
            chk("decerr_data", 64'(seen[0].data), 64'd0);
        end
        chk("decerr_ram_en", 64'(ram_en_cnt), 64'd0);

        // Longest burst.
        seen.delete();
        ar_send(4'd6, 32'h0, 8'd255, 3'd2, 2'b01);
        wait_idle();
        chk("len255_count", 64'(seen.size()), 64'd256);
        if (seen.size() == 256) begin
            chk("len255_last", 64'(seen[255].last), 64'd1);
            chk("len255_notlast", 64'(seen[254].last), 64'd0);
        end

        // Reset mid-burst.
        seen.delete();
        ar_send(4'd7, 32'h200, 8'd7, 3'd2, 2'b01);
        wait_seen(2);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_zero",
            64'({ARREADY, RVALID, RLAST, RID, RDATA,
                 RRESP, ram_en, ram_addr}), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_arready", 64'(ARREADY), 64'd1);
        chk("rst_beats", 64'(seen.size()), 64'd2);
        seen.delete();
        ar_send(4'd9, 32'h40, 8'd0, 3'd2, 2'b01);
        wait_idle();
        chk("post_rst_count", 64'(seen.size()), 64'd1);
        if (seen.size() >= 1)
            chk("post_rst_data", 64'(seen[0].data), 64'hDEADBEEF);

        // Random traffic against the model.
        rr_auto = 1'b1;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                3: a = 32'h0003_FFE0 + 32'($urandom_range(0, 31));
                4: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                5: a = $urandom;
                default: a = $urandom & 32'h0003_FFFF;
            endcase
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31))
                                              : 8'($urandom_range(0, 7));
            s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7))
                                              : 3'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                3, 4: b = 2'b00;
                5: b = 2'b10;
                6: b = 2'b11;
                default: b = 2'b01;
            endcase
            ar_send(4'($urandom), a, l, s, b);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        rr_auto = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
